// File: rtl/alu_op_sequencer_pkg.sv
// Shared state, opcode and IR-field definitions for alu_op_sequencer.
// MULDIV_EN adds the MUL/DIV opcodes and the T6 (HI write-back) state.
package alu_seq_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
`ifdef MULDIV_EN
    ST_T6   = 4'd7,
`endif
    ST_ILL  = 4'd8
  } state_e;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic pc_in;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic z_in;
    logic zlow_out;
    logic zhi_out;
  } strobe_t;

  localparam strobe_t STRB_NONE = 12'h000;

  localparam logic [OPC_W-1:0] OP_AND = 5'b00011;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADD = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHR = 5'b00111;
  localparam logic [OPC_W-1:0] OP_SHL = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROR = 5'b01001;
  localparam logic [OPC_W-1:0] OP_ROL = 5'b01010;
  localparam logic [OPC_W-1:0] OP_NEG = 5'b01011;
  localparam logic [OPC_W-1:0] OP_NOT = 5'b01100;
  localparam logic [OPC_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV = 5'b10000;

  // Register fields sit directly below the opcode, Ra first.
  function automatic int ra_lsb(input int data_w, input int opcode_w, input int idx_w);
    return data_w - opcode_w - idx_w;
  endfunction

  function automatic int rb_lsb(input int data_w, input int opcode_w, input int idx_w);
    return data_w - opcode_w - 2 * idx_w;
  endfunction

  function automatic int rc_lsb(input int data_w, input int opcode_w, input int idx_w);
    return data_w - opcode_w - 3 * idx_w;
  endfunction

  function automatic logic op_legal(input logic [OPC_W-1:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SHR,
      OP_SHL, OP_ROR, OP_ROL, OP_NEG, OP_NOT: op_legal = 1'b1;
`ifdef MULDIV_EN
      OP_MUL, OP_DIV: op_legal = 1'b1;
`endif
      default: op_legal = 1'b0;
    endcase
  endfunction

  function automatic logic op_unary(input logic [OPC_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic op_muldiv(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_op_sequencer_reg_onehot_dec.sv
// Register index to one-hot strobe decoder; all zeros when not enabled.
module reg_onehot_dec #(
  parameter int NUM_REGS = 16,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic [IDX_W-1:0]    idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // One-hot decode of the register index.
  always_comb begin
    onehot = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (en && (idx == IDX_W'(i))) onehot[i] = 1'b1;
      else onehot[i] = 1'b0;
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Hardwired Moore control sequencer: fetch T0-T2, ALU execute T3-T5 (T6 for 64-bit results).
// Define MULDIV_EN to make MUL/DIV legal with the LO (T5) / HI (T6) write-back steps.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OPCODE_W = 5,
  parameter int CNT_W    = 16
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Run,
  input  logic [DATA_W-1:0]   IR,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Zhiout,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic [OPCODE_W-1:0] AluOp,
  output logic                Busy,
  output logic                Done,
  output logic                Illegal,
  output logic [CNT_W-1:0]    InstrCount
);

  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int RA_LSB    = ra_lsb(DATA_W, OPCODE_W, REG_IDX_W);
  localparam int RB_LSB    = rb_lsb(DATA_W, OPCODE_W, REG_IDX_W);
  localparam int RC_LSB    = rc_lsb(DATA_W, OPCODE_W, REG_IDX_W);

  state_e                 state_r;
  state_e                 nxt_s;
  strobe_t                strb_r;
  strobe_t                nxt_strb_s;
  logic [OPC_W-1:0]       op_r;
  logic [OPC_W-1:0]       ir_op_s;
  logic [OPC_W-1:0]       nxt_aluop_s;
  logic [REG_IDX_W-1:0]   ra_r;
  logic [REG_IDX_W-1:0]   rc_r;
  logic [REG_IDX_W-1:0]   ir_ra_s;
  logic [REG_IDX_W-1:0]   ir_rb_s;
  logic [REG_IDX_W-1:0]   ir_rc_s;
  logic [REG_IDX_W-1:0]   rout_idx_s;
  logic [REG_IDX_W-1:0]   rin_idx_s;
  logic                   rout_en_s;
  logic                   rin_en_s;
  logic                   nxt_done_s;
  logic                   nxt_ill_s;
  logic [NUM_REGS-1:0]    rout_dec_s;
  logic [NUM_REGS-1:0]    rin_dec_s;
  logic                   unused_ir_s;
`ifdef MULDIV_EN
  logic                   nxt_hi_s;
  logic                   nxt_lo_s;
`endif

  assign ir_op_s     = OPC_W'(IR[DATA_W-1 -: OPCODE_W]);
  assign ir_ra_s     = IR[RA_LSB +: REG_IDX_W];
  assign ir_rb_s     = IR[RB_LSB +: REG_IDX_W];
  assign ir_rc_s     = IR[RC_LSB +: REG_IDX_W];
  assign unused_ir_s = ^IR[RC_LSB-1:0];

  assign PCout   = strb_r.pc_out;
  assign MARin   = strb_r.mar_in;
  assign IncPC   = strb_r.inc_pc;
  assign PCin    = strb_r.pc_in;
  assign Read    = strb_r.read;
  assign MDRin   = strb_r.mdr_in;
  assign MDRout  = strb_r.mdr_out;
  assign IRin    = strb_r.ir_in;
  assign Yin     = strb_r.y_in;
  assign Zin     = strb_r.z_in;
  assign Zlowout = strb_r.zlow_out;
  assign Zhiout  = strb_r.zhi_out;
`ifndef MULDIV_EN
  assign HIin    = 1'b0;
  assign LOin    = 1'b0;
`endif

  // Next-state logic; Run only matters in IDLE and at the final execute step.
  always_comb begin
    nxt_s = state_r;
    case (state_r)
      ST_IDLE: if (Run) nxt_s = ST_T0; else nxt_s = ST_IDLE;
      ST_T0:   nxt_s = ST_T1;
      ST_T1:   nxt_s = ST_T2;
      ST_T2:   nxt_s = ST_T3;
      ST_T3:   if (op_legal(op_r)) nxt_s = ST_T4; else nxt_s = ST_ILL;
      ST_T4:   nxt_s = ST_T5;
`ifdef MULDIV_EN
      ST_T5: begin
        if (op_muldiv(op_r)) nxt_s = ST_T6;
        else if (Run) nxt_s = ST_T0;
        else nxt_s = ST_IDLE;
      end
      ST_T6:   if (Run) nxt_s = ST_T0; else nxt_s = ST_IDLE;
`else
      ST_T5:   if (Run) nxt_s = ST_T0; else nxt_s = ST_IDLE;
`endif
      ST_ILL:  nxt_s = ST_IDLE;
      default: nxt_s = ST_IDLE;
    endcase
  end

  // Output decode from the next state; the T3 decode reads IR directly since the fields latch on that same edge.
  always_comb begin
    nxt_strb_s  = STRB_NONE;
    nxt_aluop_s = {OPC_W{1'b0}};
    rout_en_s   = 1'b0;
    rout_idx_s  = {REG_IDX_W{1'b0}};
    rin_en_s    = 1'b0;
    rin_idx_s   = {REG_IDX_W{1'b0}};
    nxt_done_s  = 1'b0;
    nxt_ill_s   = 1'b0;
`ifdef MULDIV_EN
    nxt_hi_s    = 1'b0;
    nxt_lo_s    = 1'b0;
`endif
    case (nxt_s)
      ST_T0: begin
        nxt_strb_s.pc_out = 1'b1;
        nxt_strb_s.mar_in = 1'b1;
        nxt_strb_s.inc_pc = 1'b1;
        nxt_strb_s.z_in   = 1'b1;
      end
      ST_T1: begin
        nxt_strb_s.zlow_out = 1'b1;
        nxt_strb_s.pc_in    = 1'b1;
        nxt_strb_s.read     = 1'b1;
        nxt_strb_s.mdr_in   = 1'b1;
      end
      ST_T2: begin
        nxt_strb_s.mdr_out = 1'b1;
        nxt_strb_s.ir_in   = 1'b1;
      end
      ST_T3: begin
        if (op_legal(ir_op_s) && !op_unary(ir_op_s)) begin
          rout_en_s       = 1'b1;
          rout_idx_s      = ir_rb_s;
          nxt_strb_s.y_in = 1'b1;
        end else begin
          rout_en_s = 1'b0;
        end
      end
      ST_T4: begin
        rout_en_s       = 1'b1;
        rout_idx_s      = rc_r;
        nxt_strb_s.z_in = 1'b1;
        nxt_aluop_s     = op_r;
      end
      ST_T5: begin
        nxt_strb_s.zlow_out = 1'b1;
`ifdef MULDIV_EN
        if (op_muldiv(op_r)) begin
          nxt_lo_s = 1'b1;
        end else begin
          rin_en_s   = 1'b1;
          rin_idx_s  = ra_r;
          nxt_done_s = 1'b1;
        end
`else
        rin_en_s   = 1'b1;
        rin_idx_s  = ra_r;
        nxt_done_s = 1'b1;
`endif
      end
`ifdef MULDIV_EN
      ST_T6: begin
        nxt_strb_s.zhi_out = 1'b1;
        nxt_hi_s           = 1'b1;
        nxt_done_s         = 1'b1;
      end
`endif
      ST_ILL:  nxt_ill_s  = 1'b1;
      default: nxt_strb_s = STRB_NONE;
    endcase
  end

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_rout_dec (
    .idx    (rout_idx_s),
    .en     (rout_en_s),
    .onehot (rout_dec_s)
  );

  reg_onehot_dec #(.NUM_REGS(NUM_REGS), .IDX_W(REG_IDX_W)) u_rin_dec (
    .idx    (rin_idx_s),
    .en     (rin_en_s),
    .onehot (rin_dec_s)
  );

  // State, latched instruction fields, registered outputs and retired-instruction counter.
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state_r    <= ST_IDLE;
      strb_r     <= STRB_NONE;
      op_r       <= {OPC_W{1'b0}};
      ra_r       <= {REG_IDX_W{1'b0}};
      rc_r       <= {REG_IDX_W{1'b0}};
      Rout       <= {NUM_REGS{1'b0}};
      Rin        <= {NUM_REGS{1'b0}};
      AluOp      <= {OPCODE_W{1'b0}};
      Busy       <= 1'b0;
      Done       <= 1'b0;
      Illegal    <= 1'b0;
      InstrCount <= {CNT_W{1'b0}};
`ifdef MULDIV_EN
      HIin       <= 1'b0;
      LOin       <= 1'b0;
`endif
    end else begin
      state_r <= nxt_s;
      strb_r  <= nxt_strb_s;
      if (state_r == ST_T2) begin
        op_r <= ir_op_s;
        ra_r <= ir_ra_s;
        rc_r <= ir_rc_s;
      end
      Rout    <= rout_dec_s;
      Rin     <= rin_dec_s;
      AluOp   <= OPCODE_W'(nxt_aluop_s);
      Busy    <= (nxt_s != ST_IDLE);
      Done    <= nxt_done_s;
      Illegal <= nxt_ill_s;
      if (nxt_done_s) InstrCount <= InstrCount + CNT_W'(1);
`ifdef MULDIV_EN
      HIin    <= nxt_hi_s;
      LOin    <= nxt_lo_s;
`endif
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised self-checking bench for alu_op_sequencer against a cycle-list reference model.
// Honours MULDIV_EN for the expected MUL/DIV behaviour.
module tb_alu_op_sequencer;

  localparam int CNT_W = 4;
`ifdef MULDIV_EN
  localparam int MD_EN = 1;
`else
  localparam int MD_EN = 0;
`endif
  localparam int B_PCOUT = 13, B_MARIN = 12, B_INCPC = 11, B_PCIN = 10, B_READ = 9, B_MDRIN = 8;
  localparam int B_MDROUT = 7, B_IRIN = 6, B_YIN = 5, B_ZIN = 4, B_ZLOW = 3, B_ZHI = 2, B_HIIN = 1, B_LOIN = 0;

  typedef struct packed {
    logic [13:0] strb;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  aluop;
    logic        busy;
    logic        done;
    logic        illegal;
  } obs_t;

  logic Clock = 1'b0;
  logic Clear, Run;
  logic [31:0] IR;
  logic PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhiout, HIin, LOin;
  logic [15:0] Rout, Rin;
  logic [4:0] AluOp;
  logic Busy, Done, Illegal;
  logic [CNT_W-1:0] InstrCount;

  int total = 0;
  int bad = 0;
  int exp_cnt = 0;
  obs_t idle_o = '0;
  obs_t exp_q[$];
  obs_t obs_q[$];
  logic [31:0] irs_q[$];
  int lens_q[$];

  alu_op_sequencer #(.DATA_W(32), .NUM_REGS(16), .OPCODE_W(5), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhiout(Zhiout), .HIin(HIin), .LOin(LOin),
    .Rout(Rout), .Rin(Rin), .AluOp(AluOp), .Busy(Busy), .Done(Done),
    .Illegal(Illegal), .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic obs_t sample();
    obs_t o;
    o.strb    = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhiout, HIin, LOin};
    o.rout    = Rout;
    o.rin     = Rin;
    o.aluop   = AluOp;
    o.busy    = Busy;
    o.done    = Done;
    o.illegal = Illegal;
    return o;
  endfunction

  function automatic logic [31:0] make_ir(input logic [4:0] op, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic logic [4:0] rand_legal();
    int v;
    v = $urandom_range(3, 12 + 2 * MD_EN);
    if (v == 13) return 5'b01111;
    if (v == 14) return 5'b10000;
    return 5'(v);
  endfunction

  // Reference model: appends the per-cycle output list of one instruction, returns 1 if it retires.
  function automatic bit model_instr(input logic [31:0] ir);
    obs_t s;
    logic [4:0] op;
    bit md, legal, unary;
    op    = ir[31:27];
    md    = (op == 5'b01111) || (op == 5'b10000);
    legal = (op >= 5'd3 && op <= 5'd12) || (MD_EN == 1 && md);
    unary = (op == 5'd11) || (op == 5'd12);
    s = '0; s.busy = 1'b1;
    s.strb[B_PCOUT] = 1'b1; s.strb[B_MARIN] = 1'b1; s.strb[B_INCPC] = 1'b1; s.strb[B_ZIN] = 1'b1;
    exp_q.push_back(s);
    s = '0; s.busy = 1'b1;
    s.strb[B_ZLOW] = 1'b1; s.strb[B_PCIN] = 1'b1; s.strb[B_READ] = 1'b1; s.strb[B_MDRIN] = 1'b1;
    exp_q.push_back(s);
    s = '0; s.busy = 1'b1;
    s.strb[B_MDROUT] = 1'b1; s.strb[B_IRIN] = 1'b1;
    exp_q.push_back(s);
    s = '0; s.busy = 1'b1;
    if (legal && !unary) begin
      s.rout = 16'd1 << ir[22:19];
      s.strb[B_YIN] = 1'b1;
    end
    exp_q.push_back(s);
    if (!legal) begin
      s = '0; s.busy = 1'b1; s.illegal = 1'b1;
      exp_q.push_back(s);
      return 1'b0;
    end
    s = '0; s.busy = 1'b1; s.rout = 16'd1 << ir[18:15]; s.strb[B_ZIN] = 1'b1; s.aluop = op;
    exp_q.push_back(s);
    s = '0; s.busy = 1'b1; s.strb[B_ZLOW] = 1'b1;
    if (md) begin
      s.strb[B_LOIN] = 1'b1;
      exp_q.push_back(s);
      s = '0; s.busy = 1'b1; s.strb[B_ZHI] = 1'b1; s.strb[B_HIIN] = 1'b1; s.done = 1'b1;
    end else begin
      s.rin = 16'd1 << ir[26:23];
      s.done = 1'b1;
    end
    exp_q.push_back(s);
    return 1'b1;
  endfunction

  task automatic plan();
    int n;
    exp_q.delete();
    lens_q.delete();
    foreach (irs_q[i]) begin
      n = exp_q.size();
      if (model_instr(irs_q[i])) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
      lens_q.push_back(exp_q.size() - n);
    end
    exp_q.push_back(idle_o);
  endtask

  // Issues irs_q back-to-back (Run held until the last instruction starts) and records every cycle.
  task automatic drive_seq();
    obs_q.delete();
    Run = 1'b1;
    for (int i = 0; i < irs_q.size(); i++) begin
      IR = irs_q[i];
      for (int k = 0; k < lens_q[i]; k++) begin
        @(posedge Clock); #1;
        obs_q.push_back(sample());
        if (k == 0) Run = (i < irs_q.size() - 1) ? 1'b1 : 1'b0;
        if (k == 4) IR = $urandom;
      end
    end
    @(posedge Clock); #1;
    obs_q.push_back(sample());
  endtask

  task automatic test_reset();
    Clear = 1'b1; Run = 1'b1; IR = 32'h1A920000;
    repeat (2) @(posedge Clock);
    #1;
    total++; if (sample() !== idle_o) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", sample(), idle_o); end
    total++; if (InstrCount !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", InstrCount); end
    Run = 1'b0; Clear = 1'b0;
    @(posedge Clock); #1;
    total++; if (sample() !== idle_o) begin bad++; $display("FAIL idle_after_reset got=%h exp=%h", sample(), idle_o); end
  endtask

  task automatic test_and();
    irs_q.delete(); irs_q.push_back(32'h1A920000);
    plan(); drive_seq();
    foreach (exp_q[k]) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL and_trace cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]); end
    end
    total++; if (obs_q[3].rout !== 16'h0004) begin bad++; $display("FAIL and_t3_rout got=%h exp=0004", obs_q[3].rout); end
    total++; if (obs_q[4].aluop !== 5'b00011) begin bad++; $display("FAIL and_t4_aluop got=%b exp=00011", obs_q[4].aluop); end
    total++; if (obs_q[5].rin !== 16'h0020 || obs_q[5].done !== 1'b1) begin bad++; $display("FAIL and_t5 rin=%h done=%b exp rin=0020 done=1", obs_q[5].rin, obs_q[5].done); end
    total++; if (InstrCount !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL and_count got=%0d exp=%0d", InstrCount, exp_cnt); end
  endtask

  task automatic test_illegal();
    irs_q.delete(); irs_q.push_back(32'hF0000000);
    plan(); drive_seq();
    foreach (exp_q[k]) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL ill_trace cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]); end
    end
    total++; if (obs_q[4].illegal !== 1'b1) begin bad++; $display("FAIL ill_latency got=%b exp=1", obs_q[4].illegal); end
    total++; if (InstrCount !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL ill_count got=%0d exp=%0d", InstrCount, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    irs_q.delete();
    irs_q.push_back(make_ir(5'b00101, 4'd1, 4'd2, 4'd3));
    irs_q.push_back(make_ir(5'b00101, 4'd0, 4'd0, 4'd0));
    for (int i = 0; i < 3; i++) irs_q.push_back(make_ir(rand_legal(), 4'($urandom), 4'($urandom), 4'($urandom)));
    plan(); drive_seq();
    foreach (exp_q[k]) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL b2b_trace cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]); end
    end
    total++; if (obs_q[6].strb[B_PCOUT] !== 1'b1 || obs_q[6].busy !== 1'b1) begin bad++; $display("FAIL b2b_no_gap got=%h exp T0", obs_q[6]); end
    total++; if (InstrCount !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", InstrCount, exp_cnt); end
  endtask

  task automatic test_muldiv();
    irs_q.delete(); irs_q.push_back(make_ir(5'b01111, 4'd1, 4'd2, 4'd3));
    plan(); drive_seq();
    foreach (exp_q[k]) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL mul_trace cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]); end
    end
`ifdef MULDIV_EN
    total++; if (obs_q[6].done !== 1'b1 || obs_q[6].strb[B_HIIN] !== 1'b1) begin bad++; $display("FAIL mul_t6 got=%h exp done+HIin", obs_q[6]); end
`else
    total++; if (obs_q[4].illegal !== 1'b1) begin bad++; $display("FAIL mul_illegal got=%b exp=1", obs_q[4].illegal); end
`endif
    total++; if (InstrCount !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL mul_count got=%0d exp=%0d", InstrCount, exp_cnt); end
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int t = 0; t < 12; t++) begin
      op = (t % 2 == 0) ? rand_legal() : 5'($urandom_range(0, 31));
      irs_q.delete(); irs_q.push_back(make_ir(op, 4'($urandom), 4'($urandom), 4'($urandom)));
      plan(); drive_seq();
      foreach (exp_q[k]) begin
        total++;
        if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL rand_trace op=%b cyc=%0d got=%h exp=%h", op, k, obs_q[k], exp_q[k]); end
      end
      total++; if (InstrCount !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL rand_count got=%0d exp=%0d", InstrCount, exp_cnt); end
    end
  endtask

  task automatic test_clear();
    logic [31:0] ir;
    ir = make_ir(5'b00101, 4'd7, 4'd8, 4'd9);
    exp_q.delete(); void'(model_instr(ir));
    IR = ir; Run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge Clock); #1;
      Run = 1'b0;
    end
    total++; if (sample() !== exp_q[4]) begin bad++; $display("FAIL clear_pre_t4 got=%h exp=%h", sample(), exp_q[4]); end
    Clear = 1'b1; Run = 1'b1;
    @(posedge Clock); #1;
    exp_cnt = 0;
    total++; if (sample() !== idle_o) begin bad++; $display("FAIL clear_outputs got=%h exp=%h", sample(), idle_o); end
    total++; if (InstrCount !== 4'd0) begin bad++; $display("FAIL clear_count got=%0d exp=0", InstrCount); end
    Clear = 1'b0; Run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge Clock); #1;
      total++; if (sample() !== idle_o) begin bad++; $display("FAIL clear_after cyc=%0d got=%h exp=%h", k, sample(), idle_o); end
    end
  endtask

  task automatic test_wrap();
    irs_q.delete();
    for (int i = 0; i < 15; i++) irs_q.push_back(make_ir(5'b00101, 4'($urandom), 4'($urandom), 4'($urandom)));
    plan(); drive_seq();
    total++; if (InstrCount !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL wrap_preload got=%0d exp=%0d", InstrCount, exp_cnt); end
    irs_q.delete(); irs_q.push_back(make_ir(5'b00110, 4'd0, 4'd15, 4'd15));
    plan(); drive_seq();
    foreach (exp_q[k]) begin
      total++;
      if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL wrap_trace cyc=%0d got=%h exp=%h", k, obs_q[k], exp_q[k]); end
    end
    total++; if (InstrCount !== CNT_W'(exp_cnt)) begin bad++; $display("FAIL wrap_count got=%0d exp=%0d", InstrCount, exp_cnt); end
  endtask

  initial begin
    Clear = 1'b1; Run = 1'b0; IR = 32'h0;
    test_reset();
    test_and();
    test_illegal();
    test_back_to_back();
    test_muldiv();
    test_random();
    test_clear();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Hardwired control sequencer for the register-transfer datapath. It steps the datapath through the three-cycle instruction fetch (T0–T2) and the three-operand ALU execute (T3–T5, plus T6 for 64-bit results), replacing hand-driven control sequences with a parametrised Moore FSM. It decodes opcode and register fields from the datapath's IR output and drives one-hot register select strobes, an ALU operation code, and status outputs.

## Interface
Parameters:
- DATA_W, 32, datapath/IR width
- NUM_REGS, 16, general registers; REG_IDX_W = $clog2(NUM_REGS)
- OPCODE_W, 5, opcode field width
- CNT_W, 16, retired-instruction counter width

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Clear  in  1  synchronous, active-high reset
- Run  in  1  start/continue request, sampled in IDLE and at the last execute step
- IR  in  DATA_W  datapath IR output; opcode [DATA_W-1 -: OPCODE_W], Ra, Rb, Rc in the next three REG_IDX_W fields downward
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhiout, HIin, LOin  out  1 each  datapath strobes
- Rout  out  NUM_REGS  one-hot register drive-to-bus
- Rin  out  NUM_REGS  one-hot register load
- AluOp  out  OPCODE_W  opcode presented to ALU, valid while Zin is high in T4
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse in the final execute step
- Illegal  out  1  one-cycle pulse on an undecodable opcode
- InstrCount  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, ILL. Each state lasts exactly one cycle.
- IDLE: all strobes 0. If Run = 1, next state is T0.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin.
- T3: decode IR. Opcode and Ra/Rb/Rc are latched internally.
  - Legal opcode: assert Rout[Rb] and Yin.
  - Illegal opcode: next state is ILL and no T3 strobes are asserted.
- T4: Rout[Rc], Zin, and AluOp = latched opcode.
- T5:
  - Normal ops: Zlowout, Rin[Ra], Done. Next state is T0 if Run = 1, else IDLE.
  - MUL/DIV: Zlowout, LOin. Next state is T6.
- T6: Zhiout, HIin, Done. Next state follows the same Run rule as T5.
- ILL: Illegal pulse, no writes. Next state is IDLE regardless of Run.
- Legal opcodes: AND 00011, OR 00100, ADD 00101, SUB 00110, SHR 00111, SHL 01000, ROR 01001, ROL 01010, NEG 01011, NOT 01100; MUL 01111 and DIV 10000 only with the macro (see Configuration).
- NEG and NOT are unary: T3 asserts neither Rout nor Yin, only T4's Rout[Rc] feeds the ALU.
- Ra = Rb = Rc is permitted, and R0 is writable.
- InstrCount increments on every Done and wraps from all-ones to 0. It does not increment on Illegal.

## Timing
- All outputs are registered, decoded from the next state, so each strobe is valid for the whole cycle of its state.
- Reset: state = IDLE. Every strobe, Rout, Rin, AluOp, Busy, Done, Illegal and InstrCount = 0 after the first edge with Clear = 1.
- Clear mid-operation aborts with no partial write. It has priority over Run.
- Latency from Run sampled in IDLE:
  - Done is high 6 cycles later (T5) for normal ops, 7 cycles later (T6) for MUL/DIV.
  - Illegal is high 5 cycles later.
- With Run held high, instructions issue back-to-back: T0 follows T5/T6 directly, with no IDLE gap.
- Run is ignored during T0–T4.
- Decoded fields are held stable from T3 until the next T3; IR changes after T3 have no effect.

## Configuration
- MULDIV_EN defined: MUL and DIV are legal and take the T5 (LO) / T6 (HI) path.
- MULDIV_EN undefined: opcodes 01111 and 10000 decode as illegal; HIin and LOin are tied to 0; state T6 is not built.

## Structure
- Shared package alu_seq_pkg holds:
  - state enum
  - opcode localparams
  - IR field-offset constants derived from DATA_W, OPCODE_W and REG_IDX_W
- One sub-module: reg_onehot_dec (REG_IDX_W index plus enable in, NUM_REGS one-hot out). It is instantiated twice, once for Rout and once for Rin.

## Test plan
- AND R5,R2,R4, IR = 32'h1A920000, Run pulsed:
  - T3: Rout = 1<<2, Yin
  - T4: Rout = 1<<4, Zin, AluOp = 00011
  - T5: Rin = 1<<5, Zlowout, Done
  - Afterwards: IDLE, InstrCount = 1
- Opcode 11110 (IR = 32'hF0000000): Illegal pulses 5 cycles after Run; Rin never asserted; InstrCount unchanged.
- Run held high for two ADD instructions: T0 immediately follows the first T5; InstrCount = 2; Busy stays high throughout.
- Clear asserted during T4: next cycle all outputs 0 and state IDLE; no Rin pulse ever appears.
- MUL R1,R2,R3 (opcode 01111):
  - With MULDIV_EN: T5 has Zlowout+LOin, T6 has Zhiout+HIin+Done.
  - Without MULDIV_EN: Illegal pulse instead.
- InstrCount preloaded to all-ones via 2^CNT_W−1 retired ops (CNT_W = 4 in the bench) wraps to 0 on the next Done.
